// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register file: N_REGS 32-bit registers, the last one a read-only ID constant.
// Read and write channels run as independent two-state FSMs; every output is a flop.
module axi_lite_regfile_slave #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          N_REGS     = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h4000_0000),
    parameter logic [DATA_WIDTH-1:0] ID_VALUE  = DATA_WIDTH'(32'hA11C_E001)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W   = $clog2(N_REGS);
    localparam int unsigned DEC_LSB = IDX_W + 2;
    localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(N_REGS - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // BASE_ADDR is aligned to the window size, so decode is an upper-bit compare.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:DEC_LSB] == BASE_ADDR[ADDR_WIDTH-1:DEC_LSB]) && (a[1:0] == 2'b00);
    endfunction

    w_state_e                w_state_q, w_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   regs_q [N_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [N_REGS];

    r_state_e                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_W-1:0]       wr_strb;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic                    wr_ok;

    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    // Write channel: collect AW and W in any order, commit when both are present.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        aw_hs   = awvalid && awready_q;
        w_hs    = wvalid && wready_q;
        wr_addr = aw_held_q ? awaddr_q : awaddr;
        wr_data = w_held_q ? wdata_q : wdata;
        wr_strb = w_held_q ? wstrb_q : wstrb;
        wr_idx  = wr_addr[DEC_LSB-1:2];
        wr_ok   = addr_ok(wr_addr) && (wr_idx != ID_IDX);

        case (w_state_q)
            W_IDLE: begin
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    if (wr_ok) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = awaddr;
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = wdata;
                        wstrb_d  = wstrb;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        regs_d[N_REGS-1] = ID_VALUE;
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read channel: sample the pre-write register value on the AR handshake edge.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ar_hs     = arvalid && arready_q;
        rd_idx    = araddr[DEC_LSB-1:2];

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    if (addr_ok(araddr)) begin
                        rdata_d = regs_q[rd_idx];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            for (int i = 0; i < N_REGS - 1; i++) regs_q[i] <= '0;
            regs_q[N_REGS-1] <= ID_VALUE;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents each response.
module tb_axi_lite_regfile_slave;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    always #5 aclk = ~aclk;

    axi_lite_regfile_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] b_exp_q [$];
    rexp_t      r_exp_q [$];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a valid&&ready seen here completes on the following posedge.
    always begin
        @(negedge aclk);
        #1;
        if (aresetn && bvalid && bready) begin
            if (b_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected: got bresp=%b, expected no response", bresp);
            end else begin
                chk("bresp", 64'(bresp), 64'(b_exp_q.pop_front()));
            end
        end
        if (aresetn && rvalid && rready) begin
            if (r_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL r_unexpected: got rdata=0x%0h rresp=%b, expected no response", rdata, rresp);
            end else begin
                rexp_t e;
                e = r_exp_q.pop_front();
                chk("rdata", 64'(rdata), 64'(e.data));
                chk("rresp", 64'(rresp), 64'(e.resp));
            end
        end
    end

    task automatic wait_hs();
        for (int i = 0; i < 50; i++) begin
            logic ah, wh;
            if (!awvalid && !wvalid) return;
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(negedge aclk);
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            n_total++;
            $display("FAIL write_handshake_timeout: got awvalid=%b wvalid=%b pending, expected accepted", awvalid, wvalid);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] exp);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        b_exp_q.push_back(exp);
        wait_hs();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        rexp_t e;
        e.data = d; e.resp = r;
        r_exp_q.push_back(e);
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50 && arvalid; i++) begin
            logic h;
            h = arready;
            @(negedge aclk);
            if (h) arvalid = 1'b0;
        end
        if (arvalid) begin
            n_total++;
            $display("FAIL read_handshake_timeout: got arready low, expected AR accepted");
            arvalid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (b_exp_q.size() != 0 || r_exp_q.size() != 0); i++) begin
            @(negedge aclk);
            #2;
        end
        chk("drain_pending", 64'(b_exp_q.size() + r_exp_q.size()), 64'd0);
        @(negedge aclk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_regs [7];
        exp_regs = '{32'h0, 32'h1234_5678, 32'h00BB_00DD, 32'h0, 32'h0, 32'h0, 32'h0};

        // Reset behaviour
        repeat (3) @(negedge aclk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_ready", 64'({awready, wready, arready}), 64'b111);

        // AW and W together: bvalid on the cycle after commit
        wr(32'h4000_0004, 32'h1234_5678, 4'hF, 2'b00);
        chk("same_cycle_bvalid", 64'(bvalid), 64'd1);
        rd(32'h4000_0004, 32'h1234_5678, 2'b00);
        drain();

        // W two cycles before AW, partial strobes
        wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
        b_exp_q.push_back(2'b00);
        @(negedge aclk);
        wvalid = 1'b0;
        chk("w_held_wready", 64'(wready), 64'd0);
        @(negedge aclk);
        chk("w_only_no_bvalid", 64'(bvalid), 64'd0);
        awaddr = 32'h4000_0008; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("split_commit_bvalid", 64'(bvalid), 64'd1);
        rd(32'h4000_0008, 32'h00BB_00DD, 2'b00);

        // Read-only ID register
        wr(32'h4000_001C, 32'hFFFF_FFFF, 4'hF, 2'b10);
        rd(32'h4000_001C, 32'hA11C_E001, 2'b00);

        // Invalid addresses and zero strobe
        rd(32'h4000_0020, 32'h0, 2'b10);
        rd(32'h4000_0002, 32'h0, 2'b10);
        wr(32'h3FFF_FFFC, 32'hDEAD_BEEF, 4'hF, 2'b10);
        wr(32'h4000_0024, 32'hDEAD_BEEF, 4'hF, 2'b10);
        wr(32'h4000_0006, 32'hDEAD_BEEF, 4'hF, 2'b10);
        wr(32'h4000_0004, 32'hFFFF_FFFF, 4'h0, 2'b00);
        for (int i = 0; i < 7; i++) rd(32'h4000_0000 + 32'(4 * i), exp_regs[i], 2'b00);
        drain();

        // B backpressure blocks a second write
        bready = 1'b0;
        wr(32'h4000_000C, 32'h1111_1111, 4'hF, 2'b00);
        awaddr = 32'h4000_0010; wdata = 32'h2222_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 64'({awready, wready}), 64'b00);
            chk("bp_bvalid_bresp", 64'({bvalid, bresp}), 64'b100);
            @(negedge aclk);
        end
        bready = 1'b1;
        b_exp_q.push_back(2'b00);
        wait_hs();
        rd(32'h4000_000C, 32'h1111_1111, 2'b00);
        rd(32'h4000_0010, 32'h2222_2222, 2'b00);
        drain();

        // Same-cycle read and write of reg0 returns the old value
        wr(32'h4000_0000, 32'h0000_0001, 4'hF, 2'b00);
        drain();
        fork
            wr(32'h4000_0000, 32'h0000_0002, 4'hF, 2'b00);
            rd(32'h4000_0000, 32'h0000_0001, 2'b00);
        join
        rd(32'h4000_0000, 32'h0000_0002, 2'b00);
        drain();

        // Reset with AW held and W pending aborts the write
        awaddr = 32'h4000_0000; wdata = 32'h0000_0005; wstrb = 4'hF; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("aw_held_awready", 64'(awready), 64'd0);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_ready", 64'({awready, wready, arready}), 64'b000);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("abort_ready", 64'({awready, wready, arready}), 64'b111);
        @(negedge aclk);
        chk("abort_no_bvalid", 64'(bvalid), 64'd0);
        rd(32'h4000_0000, 32'h0, 2'b00);
        rd(32'h4000_0004, 32'h0, 2'b00);
        drain();
        chk("final_no_bvalid", 64'(bvalid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
